// File: rtl/gp_regfile_mp.sv
// Multi-port general-purpose register file with two bypassing write-back ports,
// per-register pending bits and a req/gnt debug port with starvation stall.
module gp_regfile_mp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_RD       = 2,
    parameter int ZERO_REG     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wb0_en_i,
    input  logic [ADDR_W-1:0]        wb0_addr_i,
    input  logic [DATA_W-1:0]        wb0_data_i,
    input  logic                     wb1_en_i,
    input  logic [ADDR_W-1:0]        wb1_addr_i,
    input  logic [DATA_W-1:0]        wb1_data_i,
    input  logic                     busy_set_i,
    input  logic [ADDR_W-1:0]        busy_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [ADDR_W-1:0]        dbg_addr_i,
    input  logic [DATA_W-1:0]        dbg_wdata_i,
    output logic                     dbg_gnt_o,
    output logic                     dbg_rvalid_o,
    output logic [DATA_W-1:0]        dbg_rdata_o,
    output logic                     dbg_stall_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, RESP} dbg_st_e;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    dbg_st_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb0_wr, wb1_wr, dbg_wr, dbg_rd;

    assign wb0_wr = wb0_en_i && !is_zero(wb0_addr_i);
    assign wb1_wr = wb1_en_i && !is_zero(wb1_addr_i);
    assign dbg_wr = dbg_gnt_o && dbg_we_i && !is_zero(dbg_addr_i);
    assign dbg_rd = dbg_gnt_o && !dbg_we_i;

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] RA = ADDR_W'(r);
        // wb1 over wb0; debug only ever writes when both are idle
        always_ff @(posedge clk_i) begin
            if (!rst_n_i)                        mem[r] <= '0;
            else if (wb1_wr && wb1_addr_i == RA) mem[r] <= wb1_data_i;
            else if (wb0_wr && wb0_addr_i == RA) mem[r] <= wb0_data_i;
            else if (dbg_wr && dbg_addr_i == RA) mem[r] <= dbg_wdata_i;
        end

        // issue marking beats write-back clearing on the same register
        always_ff @(posedge clk_i) begin
            if (!rst_n_i)
                busy_q[r] <= 1'b0;
            else if (busy_set_i && busy_addr_i == RA && !is_zero(RA))
                busy_q[r] <= 1'b1;
            else if ((wb0_wr && wb0_addr_i == RA) || (wb1_wr && wb1_addr_i == RA))
                busy_q[r] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              h0, h1;
        assign a  = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign h0 = wb0_en_i && wb0_addr_i == a;
        assign h1 = wb1_en_i && wb1_addr_i == a;
        always_comb begin
            d = mem[a];
            if (is_zero(a)) d = '0;
            else if (h1)    d = wb1_data_i;
            else if (h0)    d = wb0_data_i;
        end
        assign rd_data_o[k*DATA_W +: DATA_W] = d;
        assign rd_busy_o[k] = busy_q[a] && !h0 && !h1 && !is_zero(a);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        dbg_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                dbg_gnt_o = rst_n_i && dbg_req_i && !wb0_en_i && !wb1_en_i;
                if (dbg_gnt_o && !dbg_we_i) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dbg_rvalid_o = (state_q == RESP);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)    dbg_rdata_o <= '0;
        else if (dbg_rd) dbg_rdata_o <= mem[dbg_addr_i];
    end

    // counts only cycles spent waiting in IDLE; RESP holds the count
    always_comb begin
        cnt_d = cnt_q;
        if (!dbg_req_i || dbg_gnt_o)
            cnt_d = '0;
        else if (state_q == IDLE && cnt_q != CNT_W'(STARVE_LIMIT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q       <= '0;
            dbg_stall_o <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dbg_stall_o <= (cnt_d == CNT_W'(STARVE_LIMIT));
        end
    end
endmodule

// File: tb/tb_gp_regfile_mp.sv
// Scoreboard bench for gp_regfile_mp: expectations queued at drive time, popped at sampling.
module tb_gp_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 2, SL = 8;

    logic          clk_i = 1'b0, rst_n_i;
    logic          wb0_en_i, wb1_en_i, busy_set_i;
    logic [AW-1:0] wb0_addr_i, wb1_addr_i, busy_addr_i, dbg_addr_i;
    logic [DW-1:0] wb0_data_i, wb1_data_i, dbg_wdata_i;
    logic [NR*AW-1:0] rd_addr_i;
    logic [NR*DW-1:0] rd_data_o;
    logic [NR-1:0] rd_busy_o;
    logic          dbg_req_i, dbg_we_i, dbg_gnt_o, dbg_rvalid_o, dbg_stall_o;
    logic [DW-1:0] dbg_rdata_o;

    int n_chk = 0, n_pass = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    gp_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb0_en_i(wb0_en_i), .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
        .wb1_en_i(wb1_en_i), .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o(dbg_rdata_o), .dbg_stall_o(dbg_stall_o));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [DW-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [DW-1:0] obs);
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        wb0_en_i = 0; wb1_en_i = 0; busy_set_i = 0; dbg_req_i = 0; dbg_we_i = 0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rd_data_o[k*DW +: DW];
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_in();
        wb0_addr_i = '0; wb1_addr_i = '0; busy_addr_i = '0; dbg_addr_i = '0;
        wb0_data_i = '0; wb1_data_i = '0; dbg_wdata_i = '0; set_rd(0, 0);
        // reset, with a debug request held: no grant while reset is low
        rst_n_i = 0; dbg_req_i = 1;
        step(); step();
        push(0); pop_chk("gnt_in_reset", DW'(dbg_gnt_o));
        dbg_req_i = 0; rst_n_i = 1;
        #1;
        push(0); pop_chk("rst_rvalid", DW'(dbg_rvalid_o));
        push(0); pop_chk("rst_rdata", dbg_rdata_o);
        push(0); pop_chk("rst_stall", DW'(dbg_stall_o));
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(31 - a));
            #1;
            push(0); pop_chk("rst_rd0", rd(0));
            push(0); pop_chk("rst_rd1", rd(1));
            push(0); pop_chk("rst_busy", DW'(rd_busy_o));
        end

        // same-address double write-back: wb1 wins, bypass and storage
        step();
        wb0_en_i = 1; wb0_addr_i = 3; wb0_data_i = 32'h11111111;
        wb1_en_i = 1; wb1_addr_i = 3; wb1_data_i = 32'h22222222;
        set_rd(3, 4);
        #1;
        push(32'h22222222); pop_chk("wb_same_bypass", rd(0));
        push(0); pop_chk("wb_same_p1", rd(1));
        step();
        wb0_addr_i = 4; wb0_data_i = 32'h44; wb1_addr_i = 6; wb1_data_i = 32'h66;
        #1;
        push(32'h22222222); pop_chk("wb_same_stored", rd(0));
        push(32'h44); pop_chk("wb0_bypass", rd(1));
        step();
        idle_in(); set_rd(4, 6);
        #1;
        push(32'h44); pop_chk("wb_diff_p0", rd(0));
        push(32'h66); pop_chk("wb_diff_p1", rd(1));

        // register 0: writes, pending marks and debug writes all ignored
        wb0_en_i = 1; wb0_addr_i = 0; wb0_data_i = 32'hDEADBEEF;
        busy_set_i = 1; busy_addr_i = 0; set_rd(0, 0);
        #1;
        push(0); pop_chk("x0_bypass", rd(0));
        push(0); pop_chk("x0_busy_now", DW'(rd_busy_o));
        step();
        idle_in(); dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 0; dbg_wdata_i = 32'hCAFEF00D;
        #1;
        push(1); pop_chk("x0_dbg_gnt", DW'(dbg_gnt_o));
        step();
        idle_in();
        #1;
        push(0); pop_chk("x0_stored", rd(0));
        push(0); pop_chk("x0_busy", DW'(rd_busy_o));

        // scoreboard: set, set-vs-clear, clear
        busy_set_i = 1; busy_addr_i = 5; set_rd(5, 6);
        step();
        busy_set_i = 0;
        #1;
        push(2'b01); pop_chk("busy_x5_set", DW'(rd_busy_o));
        wb0_en_i = 1; wb0_addr_i = 5; wb0_data_i = 32'hA5; busy_set_i = 1; busy_addr_i = 5;
        #1;
        push(32'hA5); pop_chk("x5_bypass", rd(0));
        push(0); pop_chk("x5_busy_hidden", DW'(rd_busy_o));
        step();
        idle_in();
        #1;
        push(32'hA5); pop_chk("x5_stored", rd(0));
        push(2'b01); pop_chk("x5_set_wins", DW'(rd_busy_o));
        wb1_en_i = 1; wb1_addr_i = 5; wb1_data_i = 32'hB6; set_rd(6, 5);
        #1;
        push(32'hB6); pop_chk("x5_wb1_bypass", rd(1));
        step();
        idle_in();
        #1;
        push(0); pop_chk("x5_cleared", DW'(rd_busy_o));

        // debug write then read of x7
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 7; dbg_wdata_i = 32'h1234;
        #1;
        push(1); pop_chk("dbgw_gnt", DW'(dbg_gnt_o));
        step();
        dbg_we_i = 0; busy_set_i = 1; busy_addr_i = 7;
        #1;
        push(1); pop_chk("dbgr_gnt", DW'(dbg_gnt_o));
        push(0); pop_chk("dbgr_rvalid0", DW'(dbg_rvalid_o));
        step();
        busy_set_i = 0; set_rd(7, 7);
        #1;
        push(1); pop_chk("dbgr_rvalid", DW'(dbg_rvalid_o));
        push(32'h1234); pop_chk("dbgr_rdata", dbg_rdata_o);
        push(0); pop_chk("dbgr_no_gnt_resp", DW'(dbg_gnt_o));
        push(32'h1234); pop_chk("dbgw_stored", rd(0));
        push(2'b11); pop_chk("dbgr_busy_kept", DW'(rd_busy_o));
        dbg_req_i = 0;
        step();
        #1;
        push(0); pop_chk("dbgr_rvalid_drop", DW'(dbg_rvalid_o));
        push(32'h1234); pop_chk("dbgr_rdata_hold", dbg_rdata_o);

        // starvation: core writes block the grant for 10 cycles
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 9; wb0_en_i = 1; wb0_addr_i = 9;
        for (int i = 0; i < 10; i++) begin
            wb0_data_i = 32'h900 + i;
            #1;
            push(0); pop_chk("starve_gnt", DW'(dbg_gnt_o));
            push(DW'(i >= SL)); pop_chk("starve_stall", DW'(dbg_stall_o));
            step();
        end
        wb0_en_i = 0;
        #1;
        push(1); pop_chk("starve_gnt_release", DW'(dbg_gnt_o));
        push(1); pop_chk("starve_stall_hold", DW'(dbg_stall_o));
        step();
        dbg_req_i = 0;
        #1;
        push(0); pop_chk("starve_stall_clear", DW'(dbg_stall_o));
        push(1); pop_chk("starve_rvalid", DW'(dbg_rvalid_o));
        push(32'h909); pop_chk("starve_rdata", dbg_rdata_o);
        step();

        // reset while a read response is pending
        dbg_req_i = 1; dbg_addr_i = 3;
        step();
        dbg_req_i = 0;
        #1;
        push(1); pop_chk("pre_rst_rvalid", DW'(dbg_rvalid_o));
        rst_n_i = 0;
        step();
        rst_n_i = 1; set_rd(3, 4);
        #1;
        push(0); pop_chk("midrst_rvalid", DW'(dbg_rvalid_o));
        push(0); pop_chk("midrst_rdata", dbg_rdata_o);
        push(0); pop_chk("midrst_x3", rd(0));
        push(0); pop_chk("midrst_x4", rd(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gp_regfile_mp.md
Name: gp_regfile_mp

Overview:
- Parametrised next-generation general-purpose register file for the core.
- Configurable data width, depth and read-port count.
- Two write-back ports (ALU, load) with priority and bypass.
- Per-register pending (scoreboard) bits for issue hazard detection.
- Debug port with req/gnt handshake, registered read response and a starvation counter that requests a pipeline stall.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero.
- STARVE_LIMIT, 8, debug-wait cycles before dbg_stall_o asserts (>=1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_n_i  in  1  reset, synchronous, active-low.
- wb0_en_i  in  1  write-back port 0 (ALU) enable.
- wb0_addr_i  in  ADDR_W  port 0 address.
- wb0_data_i  in  DATA_W  port 0 data.
- wb1_en_i  in  1  write-back port 1 (load) enable.
- wb1_addr_i  in  ADDR_W  port 1 address.
- wb1_data_i  in  DATA_W  port 1 data.
- busy_set_i  in  1  mark destination register pending (issue).
- busy_addr_i  in  ADDR_W  destination to mark.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy_o  out  NUM_RD  pending flag per read port, combinational.
- dbg_req_i  in  1  debug request; held until grant.
- dbg_we_i  in  1  1 = write, 0 = read.
- dbg_addr_i  in  ADDR_W  debug address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_gnt_o  out  1  request accepted this cycle.
- dbg_rvalid_o  out  1  read data valid, one-cycle pulse.
- dbg_rdata_o  out  DATA_W  debug read data.
- dbg_stall_o  out  1  requests core write-back freeze.

Behaviour:
- Reset (rst_n_i low at clk_i edge):
  - All registers, busy bits and the starvation counter clear to 0; debug FSM goes to IDLE.
  - dbg_rvalid_o = 0, dbg_rdata_o = 0, dbg_stall_o = 0.
  - dbg_gnt_o = 0 while rst_n_i is low.
  - Reset mid-transaction drops any pending rvalid.
- Writes:
  - Both wb ports enabled, same address: wb1 wins. Different addresses: both write.
  - ZERO_REG=1: writes to address 0 are ignored.
- Reads, per port, combinational, in priority order:
  1. address 0 with ZERO_REG=1 -> 0;
  2. wb1 hit (wb1_en_i and address match) -> wb1_data_i;
  3. wb0 hit -> wb0_data_i;
  4. otherwise -> stored value.
- Scoreboard:
  - busy_set_i sets the bit at busy_addr_i.
  - A core write clears the bit at its address.
  - Set and clear on the same address in the same cycle: set wins.
  - Address 0 with ZERO_REG=1 is never busy.
  - rd_busy_o = stored bit AND NOT (same-cycle write hit on that address), consistent with bypass.
  - Debug writes never change busy bits.
- Debug FSM:
  - States: IDLE, RESP.
  - dbg_gnt_o = state IDLE AND dbg_req_i AND NOT wb0_en_i AND NOT wb1_en_i (combinational; core writes have priority).
  - On granted write: store dbg_wdata_i at next edge (ignored at address 0 if ZERO_REG); stay in IDLE.
  - On granted read: dbg_rdata_o captures the stored value at dbg_addr_i at the grant edge, with no bypass (no core write that cycle by construction). Go to RESP.
  - RESP: dbg_rvalid_o = 1 for exactly one cycle, no grant possible; return to IDLE. Throughput is therefore one read per 2 cycles, one write per cycle.
  - dbg_rdata_o holds its value until the next read capture.
- Starvation:
  - The counter increments each cycle in IDLE with dbg_req_i=1 and dbg_gnt_o=0, saturating at STARVE_LIMIT.
  - It clears on grant or when dbg_req_i=0.
  - dbg_stall_o = (counter == STARVE_LIMIT), registered.
  - The core is expected to deassert wb enables while stall is high; the grant then follows.

Test Plan:
- Reset then read all addresses on every port -> rd_data_o 0, rd_busy_o 0, dbg outputs 0.
- wb0 writes x3=0x11111111 and wb1 writes x3=0x22222222 in the same cycle, port 0 reads x3 that cycle -> 0x22222222; next cycle stored value 0x22222222.
- Write x0=0xDEADBEEF via wb0, busy_set_i on x0, dbg write x0 -> reads of x0 return 0, rd_busy_o 0.
- busy_set_i x5; next cycle read x5 -> busy 1; wb0 writes x5=0xA5 with busy_set_i x5 in the same cycle -> read shows data 0xA5, busy 0 that cycle, busy 1 after the edge (set wins).
- dbg read x7 (holding 0x1234) with no core writes -> gnt in cycle 0, rvalid=1 and rdata=0x1234 in cycle 1, no gnt in cycle 1.
- dbg_req_i held with wb0_en_i=1 for 10 cycles -> no gnt, dbg_stall_o rises after 8 waiting cycles; drop wb0_en_i -> gnt that cycle, stall clears next cycle.
